// File: rtl/read_preamble_detect_if.sv
// read_preamble_detect_if: read-path bus between the command/capture logic and the DQS preamble detector
//   i_rd_en          read command pulse
//   i_pre_pattern    expected read preamble, [7:6] first
//   i_post_pattern   expected DQS pair after the last data clk
//   i_dqs_bits       sampled DQS pair ([1] earlier)
//   i_dq             two DQ beats ([2*DQ_WIDTH-1:DQ_WIDTH] first)
//   o_data           captured beats
//   o_data_valid     o_data valid
//   o_preamble_found preamble matched pulse
//   o_preamble_err   hunt timeout pulse
//   o_postamble_err  postamble mismatch pulse
//   o_cmd_overflow   dropped read request pulse
//   o_busy           detector not idle
interface read_preamble_detect_if #(parameter int DQ_WIDTH = 8);
  logic                  i_rd_en;
  logic [7:0]            i_pre_pattern;
  logic [1:0]            i_post_pattern;
  logic [1:0]            i_dqs_bits;
  logic [2*DQ_WIDTH-1:0] i_dq;
  logic [2*DQ_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_preamble_found;
  logic                  o_preamble_err;
  logic                  o_postamble_err;
  logic                  o_cmd_overflow;
  logic                  o_busy;
  modport master (
    output i_rd_en, i_pre_pattern, i_post_pattern, i_dqs_bits, i_dq,
    input  o_data, o_data_valid, o_preamble_found, o_preamble_err, o_postamble_err, o_cmd_overflow, o_busy
  );
  modport slave (
    input  i_rd_en, i_pre_pattern, i_post_pattern, i_dqs_bits, i_dq,
    output o_data, o_data_valid, o_preamble_found, o_preamble_err, o_postamble_err, o_cmd_overflow, o_busy
  );
endinterface

// File: rtl/read_preamble_detect.sv
// read_preamble_detect: hunts the sampled DQS stream for the read preamble, captures the burst, checks the postamble
//   i_clk  system clock
//   i_rst  asynchronous active-low reset
//   bus    read-path bus (slave side): request, patterns, DQS/DQ in; data, status pulses, busy out
module read_preamble_detect #(
  parameter int DQ_WIDTH  = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 15
) (
  input logic                  i_clk,
  input logic                  i_rst,
  read_preamble_detect_if.slave bus
);
  localparam int N  = BURST_LEN / 2;
  localparam int BW = $clog2(N + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, HUNT, DATA, POST} state_t;
  state_t                state_q, state_d;
  logic [7:0]            pre_q, pre_d;
  logic [5:0]            sh_q, sh_d;
  logic [CW-1:0]         hunt_cnt_q, hunt_cnt_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [1:0]            pending_q, pending_d;
  logic [2*DQ_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  found_q, found_d;
  logic                  pre_err_q, pre_err_d;
  logic                  post_err_q, post_err_d;
  logic                  ovf_q, ovf_d;
  logic                  match, rd_act, inc, dec, has_pend, enter;
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    sh_d       = sh_q;
    hunt_cnt_d = hunt_cnt_q;
    beat_d     = beat_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    found_d    = 1'b0;
    pre_err_d  = 1'b0;
    post_err_d = 1'b0;
    dec        = 1'b0;
    enter      = 1'b0;
    match      = {sh_q, bus.i_dqs_bits} == pre_q;
    // requests only queue while a burst is in flight; IDLE and POST start a hunt directly
    rd_act     = bus.i_rd_en && (state_q == HUNT || state_q == DATA);
    inc        = rd_act && pending_q != 2'd3;
    ovf_d      = rd_act && pending_q == 2'd3;
    has_pend   = pending_q != 2'd0 || inc;
    case (state_q)
      IDLE: begin
        state_d = bus.i_rd_en ? HUNT : IDLE;
        enter   = bus.i_rd_en;
      end
      HUNT: begin
        sh_d = {sh_q[3:0], bus.i_dqs_bits};
        if (match) begin
          state_d = DATA;
          found_d = 1'b1;
          beat_d  = '0;
        end else if (hunt_cnt_q == CW'(TIMEOUT - 1)) begin
          pre_err_d = 1'b1;
          state_d   = has_pend ? HUNT : IDLE;
          enter     = has_pend;
          dec       = has_pend;
        end else begin
          hunt_cnt_d = hunt_cnt_q + 1'b1;
        end
      end
      DATA: begin
        data_d  = bus.i_dq;
        valid_d = 1'b1;
        beat_d  = beat_q + 1'b1;
        // a queued read on the last data clk skips the postamble and re-hunts (interamble)
        if (beat_q == BW'(N - 1)) begin
          state_d = has_pend ? HUNT : POST;
          enter   = has_pend;
          dec     = has_pend;
        end
      end
      POST: begin
        post_err_d = bus.i_dqs_bits != bus.i_post_pattern;
        state_d    = bus.i_rd_en ? HUNT : IDLE;
        enter      = bus.i_rd_en;
      end
    endcase
    if (enter) begin
      pre_d      = bus.i_pre_pattern;
      sh_d       = '0;
      hunt_cnt_d = '0;
    end
    pending_d = pending_q + {1'b0, inc} - {1'b0, dec};
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      sh_q       <= '0;
      hunt_cnt_q <= '0;
      beat_q     <= '0;
      pending_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      found_q    <= 1'b0;
      pre_err_q  <= 1'b0;
      post_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      sh_q       <= sh_d;
      hunt_cnt_q <= hunt_cnt_d;
      beat_q     <= beat_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      found_q    <= found_d;
      pre_err_q  <= pre_err_d;
      post_err_q <= post_err_d;
      ovf_q      <= ovf_d;
    end
  end
  assign bus.o_data           = data_q;
  assign bus.o_data_valid     = valid_q;
  assign bus.o_preamble_found = found_q;
  assign bus.o_preamble_err   = pre_err_q;
  assign bus.o_postamble_err  = post_err_q;
  assign bus.o_cmd_overflow   = ovf_q;
  assign bus.o_busy           = state_q != IDLE;
endmodule

// File: tb/tb_read_preamble_detect.sv
// tb_read_preamble_detect: directed self-checking bench for read_preamble_detect
module tb_read_preamble_detect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic anyv;
  always #5 clk = ~clk;
  read_preamble_detect_if #(.DQ_WIDTH(8)) bus ();
  read_preamble_detect #(.DQ_WIDTH(8), .BURST_LEN(16), .TIMEOUT(15)) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .bus  (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rd, input logic [1:0] dqs, input logic [15:0] dq);
    bus.i_rd_en    = rd;
    bus.i_dqs_bits = dqs;
    bus.i_dq       = dq;
    tick();
  endtask
  task automatic hunt(input logic rd_first, input int n11);
    if (rd_first) begin
      drive(1'b1, 2'b00, 16'h0);
      chk("busy_after_rd", 32'(bus.o_busy), 1);
    end
    for (int i = 0; i < n11; i++) begin
      drive(1'b0, 2'b11, 16'h0);
      chk("no_post_in_interamble", 32'(bus.o_postamble_err), 0);
    end
    drive(1'b0, 2'b00, 16'h0);
    drive(1'b0, 2'b00, 16'h0);
    drive(1'b0, 2'b10, 16'h0);
    chk("found_early", 32'(bus.o_preamble_found), 0);
    drive(1'b0, 2'b10, 16'h0);
    chk("found", 32'(bus.o_preamble_found), 1);
  endtask
  task automatic burst(input logic [15:0] base, input logic [7:0] rd_mask, input logic [7:0] ovf_mask, input int nb);
    for (int i = 0; i < nb; i++) begin
      drive(rd_mask[i], 2'b00, base + 16'(i));
      chk("valid", 32'(bus.o_data_valid), 1);
      chk("data", 32'(bus.o_data), 32'(base + 16'(i)));
      chk("overflow", 32'(bus.o_cmd_overflow), 32'(ovf_mask[i]));
    end
  endtask
  task automatic post(input logic [1:0] dqs, input logic exp_err);
    drive(1'b0, dqs, 16'h0);
    chk("valid_end", 32'(bus.o_data_valid), 0);
    chk("post_err", 32'(bus.o_postamble_err), 32'(exp_err));
    chk("busy_end", 32'(bus.o_busy), 0);
  endtask
  initial begin
    bus.i_rd_en = 1'b0;
    bus.i_pre_pattern = 8'h0A;
    bus.i_post_pattern = 2'b00;
    bus.i_dqs_bits = 2'b00;
    bus.i_dq = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_data_valid), 0);
    chk("rst_data", 32'(bus.o_data), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_found", 32'(bus.o_preamble_found), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // basic read
    hunt(1'b1, 0);
    burst(16'h0001, 8'h00, 8'h00, 8);
    post(2'b00, 1'b0);
    chk("t1_pre_err", 32'(bus.o_preamble_err), 0);
    // hunt timeout
    anyv = 1'b0;
    drive(1'b1, 2'b00, 16'h0);
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 2'b11, 16'h0);
      anyv |= bus.o_data_valid;
      if (i == 14) chk("pre_err_early", 32'(bus.o_preamble_err), 0);
    end
    chk("pre_err", 32'(bus.o_preamble_err), 1);
    chk("timeout_busy", 32'(bus.o_busy), 0);
    chk("timeout_no_valid", 32'(anyv), 0);
    drive(1'b0, 2'b00, 16'h0);
    chk("pre_err_pulse", 32'(bus.o_preamble_err), 0);
    // interamble
    hunt(1'b1, 0);
    burst(16'h1000, 8'b0000_0100, 8'h00, 8);
    chk("interamble_busy", 32'(bus.o_busy), 1);
    hunt(1'b0, 1);
    burst(16'h2000, 8'h00, 8'h00, 8);
    post(2'b00, 1'b0);
    // postamble mismatch
    hunt(1'b1, 0);
    burst(16'h0010, 8'h00, 8'h00, 8);
    post(2'b10, 1'b1);
    drive(1'b0, 2'b00, 16'h0);
    chk("post_err_pulse", 32'(bus.o_postamble_err), 0);
    // async reset mid-burst
    hunt(1'b1, 0);
    burst(16'h0100, 8'h00, 8'h00, 4);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(bus.o_data_valid), 0);
    chk("arst_data", 32'(bus.o_data), 0);
    chk("arst_busy", 32'(bus.o_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hunt(1'b1, 0);
    burst(16'h0200, 8'h00, 8'h00, 8);
    post(2'b00, 1'b0);
    // pending saturation and overflow
    hunt(1'b1, 0);
    burst(16'h0300, 8'b0001_1110, 8'b0001_0000, 8);
    hunt(1'b0, 1);
    burst(16'h0400, 8'h00, 8'h00, 8);
    hunt(1'b0, 1);
    burst(16'h0500, 8'h00, 8'h00, 8);
    hunt(1'b0, 1);
    burst(16'h0600, 8'h00, 8'h00, 8);
    post(2'b00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
